// File: rtl/mem_stream_reader_if.sv
// Port bundle for mem_stream_reader: command/status, DataMem secondary read port, output stream.
// Stream handshake: a word transfers on a rising clk edge where out_valid & out_ready are both 1.
// out_valid never depends on out_ready, and out_data/out_valid hold while stalled.
interface mem_stream_reader_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] cfg_base;
    logic [LEN_W-1:0]  cfg_len;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  start, cfg_base, cfg_len, mem_rdata, out_ready,
        output busy, done, mem_addr, out_data, out_valid
    );

    modport master (
        output start, cfg_base, cfg_len, mem_rdata, out_ready,
        input  busy, done, mem_addr, out_data, out_valid
    );
endinterface

// File: rtl/mem_stream_reader.sv
// Streams cfg_len words starting at cfg_base from DataMem's secondary read port into a
// credit-limited FIFO that feeds a valid/ready consumer.
module mem_stream_reader #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 1,
    parameter int ADDR_STEP  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_stream_reader_if.slave  bus,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

    localparam int PW = $clog2(FIFO_DEPTH);

    state_t            state, state_nx;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  sent;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_issue;
    logic              rd_pend;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       fifo_count;
    logic [PW+1:0]     committed;
    logic              start_acc, issue_now, fifo_wr, pop;

    // Words already owed to the FIFO: stored, being read now, or still in the memory pipeline.
    assign committed = {1'b0, fifo_count} + {{(PW+1){1'b0}}, rd_issue} + {{(PW+1){1'b0}}, rd_pend};
    assign fifo_wr   = (RD_LATENCY == 0) ? rd_issue : rd_pend;
    assign pop       = bus.out_valid & bus.out_ready;

    assign bus.out_valid = (fifo_count != '0);
    assign bus.out_data  = fifo_mem[rd_ptr];
    assign bus.mem_addr  = addr_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FINISH);
    assign state_dbg     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        start_acc = 1'b0;
        issue_now = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    start_acc = 1'b1;
                    state_nx  = (bus.cfg_len != '0) ? FETCH : FINISH;
                end
            end
            FETCH: begin
                if (issued == len_q)
                    state_nx = DRAIN;
                else if (committed < (PW+2)'(FIFO_DEPTH))
                    issue_now = 1'b1;
            end
            DRAIN: begin
                if (pop && (sent == len_q - LEN_W'(1)))
                    state_nx = FINISH;
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The start edge itself issues the first read at cfg_base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            issued   <= '0;
            sent     <= '0;
            addr_q   <= '0;
            rd_issue <= 1'b0;
            rd_pend  <= 1'b0;
        end else begin
            rd_pend <= (RD_LATENCY != 0) ? rd_issue : 1'b0;
            if (start_acc) begin
                len_q <= bus.cfg_len;
                if (bus.cfg_len != '0) begin
                    addr_q   <= bus.cfg_base;
                    issued   <= LEN_W'(1);
                    rd_issue <= 1'b1;
                end else begin
                    issued   <= '0;
                    rd_issue <= 1'b0;
                end
            end else if (issue_now) begin
                addr_q   <= addr_q + ADDR_W'(ADDR_STEP);
                issued   <= issued + LEN_W'(1);
                rd_issue <= 1'b1;
            end else begin
                rd_issue <= 1'b0;
            end

            if (start_acc)  sent <= '0;
            else if (pop)   sent <= sent + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) begin
                fifo_mem[wr_ptr] <= bus.mem_rdata;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_wr, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader: table of transfers plus a reset-mid-transfer sequence.
module tb_mem_stream_reader;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  typedef struct {
    logic [31:0] base;
    logic [15:0] len;
    logic [7:0]  rdy_pat;
    bit          second_start;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    logic [31:0] exp_addr2;
    int          exp_first_cyc;
    int          exp_done_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] state_dbg;

  mem_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  mem_stream_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .FIFO_DEPTH(4), .RD_LATENCY(1), .ADDR_STEP(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // DataMem secondary port: synchronous read, one cycle of latency; word i holds (i+1)*17.
  logic [DATA_W-1:0] dmem [0:255];
  always @(posedge clk) bus.mem_rdata <= dmem[bus.mem_addr[7:0]];

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_xfer(input vec_t v, input string tag);
    int issued, popped, first_cyc, done_cyc, done_cnt;
    logic [31:0] last_addr, first_data, last_data, prev_data, a;
    bit prev_stall;
    exp_q.delete();
    for (int i = 0; i < int'(v.len); i++) begin
      a = v.base + 32'(i);
      exp_q.push_back(dmem[a[7:0]]);
    end
    @(negedge clk);
    last_addr = bus.mem_addr;
    bus.cfg_base = v.base;
    bus.cfg_len  = v.len;
    bus.start    = 1'b1;
    issued = 0; popped = 0; first_cyc = -1; done_cyc = -1; done_cnt = 0;
    prev_stall = 1'b0; prev_data = '0; first_data = '0; last_data = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      bus.start = v.second_start && (cyc == 1);
      if (v.second_start && cyc == 1) begin
        bus.cfg_base = 32'h80;
        bus.cfg_len  = 16'd9;
      end
      bus.out_ready = v.rdy_pat[cyc % 8];
      #1;
      if (cyc == 0) begin
        check({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
        if (v.len != 0) begin
          check({tag, " addr0"}, bus.mem_addr, v.base);
          issued = 1;
          last_addr = bus.mem_addr;
        end
      end else if (bus.mem_addr != last_addr) begin
        issued++;
        last_addr = bus.mem_addr;
      end
      if (cyc == 2 && v.len >= 3) check({tag, " addr2"}, bus.mem_addr, v.exp_addr2);
      check({tag, " credit"}, 32'((issued - popped) <= 4), 32'd1);
      if (prev_stall) begin
        check({tag, " stall_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, " stall_data"}, bus.out_data, prev_data);
      end
      if (bus.out_valid && first_cyc < 0) first_cyc = cyc;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s extra_word: got 0x%0h expected none", tag, bus.out_data);
        end else begin
          check({tag, " data"}, bus.out_data, exp_q.pop_front());
        end
        if (popped == 0) first_data = bus.out_data;
        last_data = bus.out_data;
        popped++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        check({tag, " busy_after_done"}, 32'(bus.busy), 32'd0);
        break;
      end
    end
    bus.start = 1'b0;
    check({tag, " done_cycle"}, 32'(done_cyc), 32'(v.exp_done_cyc));
    check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " words_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, " reads_issued"}, 32'(issued), 32'(v.len));
    check({tag, " first_valid_cycle"}, 32'(first_cyc), 32'(v.exp_first_cyc));
    if (v.len != 0) begin
      check({tag, " first_word"}, first_data, v.exp_first);
      check({tag, " last_word"}, last_data, v.exp_last);
    end
    check({tag, " idle_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int popped;
    logic [31:0] mid_exp [2];
    vec_t rv;
    for (int i = 0; i < 256; i++) dmem[i] = 32'((i + 1) * 17);
    bus.start = 1'b0;
    bus.cfg_base = '0;
    bus.cfg_len = '0;
    bus.out_ready = 1'b0;

    //            base          len  rdy    2nd  first         last          addr@c2       fc  dc
    vecs[0] = '{32'h0,        16'd4, 8'hFF, 0, 32'h11,   32'h44,   32'h2,   2,  6};
    vecs[1] = '{32'h0,        16'd8, 8'h99, 0, 32'h11,   32'h88,   32'h2,   2, 17};
    vecs[2] = '{32'h0,        16'd0, 8'hFF, 0, 32'h0,    32'h0,    32'h0,  -1,  0};
    vecs[3] = '{32'hFFFFFFFE, 16'd3, 8'hFF, 0, 32'h10EF, 32'h11,   32'h0,   2,  5};
    vecs[4] = '{32'h20,       16'd4, 8'hFF, 1, 32'h231,  32'h264,  32'h22,  2,  6};

    // Reset and idle
    repeat (3) @(negedge clk);
    #1;
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_data", bus.out_data, 32'h0);
    check("rst mem_addr", bus.mem_addr, 32'h0);
    check("rst state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("idle busy", 32'(bus.busy), 32'd0);
    check("idle out_valid", 32'(bus.out_valid), 32'd0);
    check("idle mem_addr", bus.mem_addr, 32'h0);

    for (int i = 0; i < 5; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

    // Reset after two of six words have been handed over
    mid_exp[0] = 32'h11;
    mid_exp[1] = 32'h22;
    @(negedge clk);
    bus.cfg_base = 32'h0;
    bus.cfg_len = 16'd6;
    bus.start = 1'b1;
    bus.out_ready = 1'b1;
    popped = 0;
    for (int cyc = 0; cyc < 20 && popped < 2; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.out_valid && bus.out_ready) begin
        check("midrst data", bus.out_data, mid_exp[popped]);
        popped++;
      end
    end
    check("midrst words_before_reset", 32'(popped), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst mem_addr", bus.mem_addr, 32'h0);
    check("midrst state", 32'(state_dbg), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("midrst no_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("midrst idle_valid", 32'(bus.out_valid), 32'd0);
    rv = '{32'h10, 16'd2, 8'hFF, 0, 32'h121, 32'h132, 32'h0, 2, 4};
    run_xfer(rv, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
